// File: rtl/histo_equalize_lut_pkg.sv
`default_nettype none
// ============================================================================
// Module      : histo_equalize_lut_pkg
// Description : Shared types and width helpers for the histogram-equalisation
//               LUT builder (state encoding, accumulator and product widths).
// Revision    : 1.0 - initial release
// ============================================================================
package histo_equalize_lut_pkg;

    // Two-state controller: collect the histogram, then map pixels.
    typedef enum logic [0:0] {
        ST_BUILD = 1'b0,
        ST_MAP   = 1'b1
    } lut_state_e;

    // Running CDF must hold the sum of P_NUM_BIN counts of P_CW bits each.
    function automatic int acc_width(input int cw, input int dw);
        return cw + dw;
    endfunction

    // CDF times (P_NUM_BIN-1) with no truncation before the shift.
    function automatic int prod_width(input int cw, input int dw);
        return cw + 2 * dw;
    endfunction

endpackage : histo_equalize_lut_pkg
`default_nettype wire

// File: rtl/histo_lut_ram.sv
`default_nettype none
// ============================================================================
// Module      : histo_lut_ram
// Description : P_NUM_BIN x P_DW register file, synchronous write,
//               asynchronous read, asynchronous active-high reset to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module histo_lut_ram #(
    parameter int P_DW      = 3,
    parameter int P_NUM_BIN = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            we_i,
    input  logic [P_DW-1:0] waddr_i,
    input  logic [P_DW-1:0] wdata_i,
    input  logic [P_DW-1:0] raddr_i,
    output logic [P_DW-1:0] rdata_o
);

    logic [P_DW-1:0] mem_q [P_NUM_BIN];

    generate
        for (genvar gi = 0; gi < P_NUM_BIN; gi++) begin : g_word
            // One storage word per bin, cleared by reset, written on its address.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    mem_q[gi] <= '0;
                end else if (we_i && (waddr_i == P_DW'(gi))) begin
                    mem_q[gi] <= wdata_i;
                end
            end
        end
    endgenerate

    assign rdata_o = mem_q[raddr_i];

endmodule : histo_lut_ram
`default_nettype wire

// File: rtl/histo_equalize_lut.sv
`default_nettype none
// ============================================================================
// Module      : histo_equalize_lut
// Description : Builds a histogram-equalisation LUT from a streamed histogram
//               (one bin count per beat) and then maps pixels through it with
//               a 1-cycle, full-throughput, back-pressurable output register.
// Revision    : 1.0 - initial release
// ============================================================================
module histo_equalize_lut
    import histo_equalize_lut_pkg::*;
#(
    parameter int P_DW        = 3,
    parameter int P_NUM_BIN   = 8,
    parameter int P_CW        = 8,
    parameter int P_LOG2_NPIX = 4
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic [P_CW-1:0] s_tdata,
    input  logic            s_tvalid,
    input  logic            s_tlast,
    output logic            s_tready,
    input  logic            lut_clear,
    output logic            lut_ready,
    output logic            lut_err,
    input  logic [P_DW-1:0] pix_i,
    input  logic            pix_valid,
    output logic            pix_ready,
    output logic [P_DW-1:0] pix_o,
    output logic            pix_o_valid,
    input  logic            pix_o_ready
);

    localparam int              C_ACC_W  = acc_width(P_CW, P_DW);
    localparam int              C_PROD_W = prod_width(P_CW, P_DW);
    localparam int              C_MAX    = P_NUM_BIN - 1;
    localparam logic [P_DW-1:0] C_K_LAST = P_DW'(C_MAX);

    lut_state_e          state_q, state_d;
    logic [P_DW-1:0]     k_q, k_d;
    logic [C_ACC_W-1:0]  cdf_q, cdf_d;
    logic                lut_ready_q, lut_ready_d;
    logic                lut_err_q, lut_err_d;
    logic [P_DW-1:0]     pix_o_q, pix_o_d;
    logic                pix_o_valid_q, pix_o_valid_d;
    logic                run_q;

    logic                w_beat;
    logic                w_pix_acc;
    logic                w_lut_we;
    logic [C_ACC_W-1:0]  w_sum;
    logic [C_PROD_W-1:0] w_prod;
    logic [C_PROD_W-1:0] w_scaled;
    logic [P_DW-1:0]     w_lut_wdata;
    logic [P_DW-1:0]     w_lut_rdata;

    // run_q keeps s_tready low while reset is held and for the edge it releases on.
    assign s_tready    = (state_q == ST_BUILD) && run_q;
    assign pix_ready   = (state_q == ST_MAP) && (!pix_o_valid_q || pix_o_ready);
    assign lut_ready   = lut_ready_q;
    assign lut_err     = lut_err_q;
    assign pix_o       = pix_o_q;
    assign pix_o_valid = pix_o_valid_q;

    assign w_beat    = s_tvalid && s_tready && !lut_clear;
    assign w_pix_acc = pix_valid && pix_ready;

    // Equalised level for the current bin: saturated (CDF * max) >> log2(npix).
    assign w_sum       = cdf_q + {{P_DW{1'b0}}, s_tdata};
    assign w_prod      = C_PROD_W'(w_sum) * C_PROD_W'(C_MAX);
    assign w_scaled    = w_prod >> P_LOG2_NPIX;
    assign w_lut_wdata = (w_scaled > C_PROD_W'(C_MAX)) ? C_K_LAST : w_scaled[P_DW-1:0];

    histo_lut_ram #(
        .P_DW      (P_DW),
        .P_NUM_BIN (P_NUM_BIN)
    ) u_lut_ram (
        .clk_i   (aclk),
        .rst_i   (areset),
        .we_i    (w_lut_we),
        .waddr_i (k_q),
        .wdata_i (w_lut_wdata),
        .raddr_i (pix_i),
        .rdata_o (w_lut_rdata)
    );

    // Controller state, bin index, running CDF and status flags.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_BUILD;
            k_q         <= '0;
            cdf_q       <= '0;
            lut_ready_q <= 1'b0;
            lut_err_q   <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cdf_q       <= cdf_d;
            lut_ready_q <= lut_ready_d;
            lut_err_q   <= lut_err_d;
            run_q       <= 1'b1;
        end
    end

    // Next-state logic: accumulate bins in BUILD, lut_clear always restarts.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        cdf_d       = cdf_q;
        lut_ready_d = lut_ready_q;
        lut_err_d   = lut_err_q;
        w_lut_we    = 1'b0;
        case (state_q)
            ST_BUILD: begin
                if (lut_clear) begin
                    // A coincident beat is dropped: the rebuild starts clean.
                    k_d         = '0;
                    cdf_d       = '0;
                    lut_ready_d = 1'b0;
                    lut_err_d   = 1'b0;
                end else if (w_beat) begin
                    w_lut_we = 1'b1;
                    if (k_q == C_K_LAST) begin
                        state_d     = ST_MAP;
                        lut_ready_d = 1'b1;
                        k_d         = '0;
                        cdf_d       = '0;
                        if (!s_tlast) begin
                            lut_err_d = 1'b1;
                        end
                    end else if (s_tlast) begin
                        // Short frame: flag it and wait for a fresh histogram.
                        lut_err_d   = 1'b1;
                        lut_ready_d = 1'b0;
                        k_d         = '0;
                        cdf_d       = '0;
                    end else begin
                        k_d   = k_q + P_DW'(1);
                        cdf_d = w_sum;
                    end
                end
            end
            ST_MAP: begin
                if (lut_clear) begin
                    state_d     = ST_BUILD;
                    lut_ready_d = 1'b0;
                    lut_err_d   = 1'b0;
                    k_d         = '0;
                    cdf_d       = '0;
                end
            end
            default: begin
                state_d = ST_BUILD;
            end
        endcase
    end

    // Output register of the pixel mapping pipeline.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pix_o_q       <= '0;
            pix_o_valid_q <= 1'b0;
        end else begin
            pix_o_q       <= pix_o_d;
            pix_o_valid_q <= pix_o_valid_d;
        end
    end

    // Load a new mapped pixel when accepted, otherwise hold until consumed.
    always_comb begin
        pix_o_d       = pix_o_q;
        pix_o_valid_d = pix_o_valid_q;
        if (w_pix_acc) begin
            pix_o_d       = w_lut_rdata;
            pix_o_valid_d = 1'b1;
        end else if (pix_o_ready) begin
            pix_o_valid_d = 1'b0;
        end
    end

endmodule : histo_equalize_lut
`default_nettype wire

// File: tb/tb_histo_equalize_lut.sv
`default_nettype none
// ============================================================================
// Module      : tb_histo_equalize_lut
// Description : Self-checking bench for histo_equalize_lut with directed
//               frames and randomized histograms / pixel traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_histo_equalize_lut;

    localparam int DW = 3;
    localparam int NB = 8;
    localparam int CW = 8;
    localparam int LN = 4;

    typedef int bins_t [NB];

    logic          aclk = 1'b0;
    logic          areset;
    logic [CW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic          lut_clear;
    logic          lut_ready;
    logic          lut_err;
    logic [DW-1:0] pix_i;
    logic          pix_valid;
    logic          pix_ready;
    logic [DW-1:0] pix_o;
    logic          pix_o_valid;
    logic          pix_o_ready;

    int checks = 0;
    int errors = 0;
    int model_lut [NB];
    int exp_q [$];

    histo_equalize_lut #(
        .P_DW        (DW),
        .P_NUM_BIN   (NB),
        .P_CW        (CW),
        .P_LOG2_NPIX (LN)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .s_tready    (s_tready),
        .lut_clear   (lut_clear),
        .lut_ready   (lut_ready),
        .lut_err     (lut_err),
        .pix_i       (pix_i),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_o       (pix_o),
        .pix_o_valid (pix_o_valid),
        .pix_o_ready (pix_o_ready)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: LUT from prefix sums of the histogram, scaled and saturated.
    function automatic void build_model(input bins_t b);
        int pref;
        int v;
        pref = 0;
        for (int k = 0; k < NB; k++) begin
            pref += b[k];
            v = (pref * (NB - 1)) >> LN;
            model_lut[k] = (v > NB - 1) ? NB - 1 : v;
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_tready"}, s_tready, 0);
        chk({tag, "_pix_ready"}, pix_ready, 0);
        chk({tag, "_lut_ready"}, lut_ready, 0);
        chk({tag, "_lut_err"}, lut_err, 0);
        chk({tag, "_pix_o_valid"}, pix_o_valid, 0);
        chk({tag, "_pix_o"}, pix_o, 0);
    endtask

    // Assert reset at a negedge, hold, then release and watch s_tready return.
    task automatic do_reset(input string tag);
        areset = 1'b1;
        #1;
        check_reset_outputs(tag);
        @(negedge aclk);
        @(negedge aclk);
        check_reset_outputs(tag);
        areset = 1'b0;
        #1;
        chk({tag, "_tready_release"}, s_tready, 0);
        @(negedge aclk);
        chk({tag, "_tready_up"}, s_tready, 1);
    endtask

    // Drive nbeats histogram beats back-to-back; tlast on beat index tlast_at.
    task automatic send_frame(input bins_t b, input int nbeats, input int tlast_at);
        for (int i = 0; i < nbeats; i++) begin
            @(negedge aclk);
            chk("beat_s_tready", s_tready, 1);
            s_tvalid = 1'b1;
            s_tdata  = CW'(b[i]);
            s_tlast  = (i == tlast_at);
        end
        @(negedge aclk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic clear_pulse();
        lut_clear = 1'b1;
        @(negedge aclk);
        lut_clear = 1'b0;
    endtask

    // Push one pixel through and check the result exactly one cycle later.
    task automatic map_one(input int p);
        pix_i       = DW'(p);
        pix_valid   = 1'b1;
        pix_o_ready = 1'b1;
        #1;
        chk("map_pix_ready", pix_ready, 1);
        @(negedge aclk);
        pix_valid = 1'b0;
        chk("map_valid", pix_o_valid, 1);
        chk($sformatf("map_pix%0d", p), pix_o, model_lut[p]);
    endtask

    task automatic check_all_lut();
        for (int p = 0; p < NB; p++) map_one(p);
        @(negedge aclk);
    endtask

    // Pixel traffic with scoreboard; directed=1 streams 0..n-1 with a 3-cycle stall.
    task automatic stream(input int n, input int stall_pct, input bit directed);
        int            sent;
        bit            prev_stall;
        logic [DW-1:0] prev_o;
        int            cyc;
        sent       = 0;
        prev_stall = 1'b0;
        prev_o     = '0;
        cyc        = 0;
        while ((sent < n || exp_q.size() > 0) && cyc < n * 8 + 50) begin
            if (directed) begin
                pix_valid   = (sent < n);
                pix_i       = DW'(sent);
                pix_o_ready = !(cyc >= 3 && cyc <= 5);
            end else begin
                pix_valid   = (sent < n) && ($urandom_range(0, 3) != 0);
                pix_i       = DW'($urandom_range(0, NB - 1));
                pix_o_ready = ($urandom_range(0, 99) >= stall_pct);
            end
            #1;
            if (prev_stall) begin
                chk("hold_valid", pix_o_valid, 1);
                chk("hold_data", pix_o, prev_o);
            end
            chk("pix_ready_rule", pix_ready, (!pix_o_valid) || pix_o_ready);
            if (pix_o_valid && pix_o_ready) begin
                if (exp_q.size() == 0) chk("pix_out_unexpected", pix_o_valid, 0);
                else                   chk("pix_out", pix_o, exp_q.pop_front());
            end
            if (pix_valid && pix_ready) begin
                exp_q.push_back(model_lut[pix_i]);
                sent++;
            end
            prev_stall = pix_o_valid && !pix_o_ready;
            prev_o     = pix_o;
            @(negedge aclk);
            cyc++;
        end
        pix_valid   = 1'b0;
        pix_o_ready = 1'b1;
        chk("stream_sent", sent, n);
        chk("stream_drained", exp_q.size(), 0);
        exp_q.delete();
        @(negedge aclk);
    endtask

    bins_t uni, single, sat, rnd, junk;

    initial begin
        uni    = '{2, 2, 2, 2, 2, 2, 2, 2};
        single = '{16, 0, 0, 0, 0, 0, 0, 0};
        sat    = '{4, 4, 4, 4, 4, 4, 4, 4};
        junk   = '{50, 50, 50, 50, 50, 50, 50, 50};
        areset = 1'b1; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        lut_clear = 1'b0; pix_i = '0; pix_valid = 1'b0; pix_o_ready = 1'b1;
        @(negedge aclk);
        do_reset("por");

        // Uniform histogram -> identity LUT
        build_model(uni);
        send_frame(uni, 8, 7);
        chk("uni_lut_ready", lut_ready, 1);
        chk("uni_lut_err", lut_err, 0);
        chk("uni_s_tready", s_tready, 0);
        map_one(5);
        check_all_lut();

        // Single populated bin -> all levels saturate at 7
        clear_pulse();
        chk("clr_lut_ready", lut_ready, 0);
        chk("clr_s_tready", s_tready, 1);
        chk("clr_pix_ready", pix_ready, 0);
        build_model(single);
        send_frame(single, 8, 7);
        map_one(3);
        check_all_lut();

        // Frame sum beyond npix -> saturation
        clear_pulse();
        build_model(sat);
        send_frame(sat, 8, 7);
        check_all_lut();

        // Early tlast, then a clean frame; error stays sticky
        clear_pulse();
        send_frame(junk, 3, 2);
        chk("early_err", lut_err, 1);
        chk("early_ready", lut_ready, 0);
        chk("early_tready", s_tready, 1);
        build_model(uni);
        send_frame(uni, 8, 7);
        chk("after_early_ready", lut_ready, 1);
        chk("after_early_err", lut_err, 1);
        check_all_lut();

        // Clear in MAP with pending output: pix_ready drops, output persists
        pix_i = 3'd6; pix_valid = 1'b1; pix_o_ready = 1'b0; lut_clear = 1'b1;
        @(negedge aclk);
        pix_valid = 1'b0; lut_clear = 1'b0;
        chk("clrmap_pix_ready", pix_ready, 0);
        chk("clrmap_pend_valid", pix_o_valid, 1);
        chk("clrmap_pend_data", pix_o, model_lut[6]);
        chk("clrmap_err_cleared", lut_err, 0);
        chk("clrmap_lut_ready", lut_ready, 0);
        @(negedge aclk);
        chk("clrmap_still_held", pix_o_valid, 1);
        pix_o_ready = 1'b1;
        @(negedge aclk);
        chk("clrmap_consumed", pix_o_valid, 0);

        // Clear coinciding with a beat in BUILD: beat discarded
        send_frame(junk, 2, -1);
        s_tvalid = 1'b1; s_tdata = 8'd99; lut_clear = 1'b1;
        @(negedge aclk);
        s_tvalid = 1'b0; lut_clear = 1'b0;
        build_model(uni);
        send_frame(uni, 8, 7);
        chk("clrbeat_ready", lut_ready, 1);
        chk("clrbeat_err", lut_err, 0);
        check_all_lut();

        // Directed backpressure: 0..7 back-to-back with a 3-cycle stall
        stream(8, 0, 1'b1);

        // Last beat without tlast: LUT valid but framing error flagged
        clear_pulse();
        build_model(sat);
        send_frame(sat, 8, -1);
        chk("notlast_ready", lut_ready, 1);
        chk("notlast_err", lut_err, 1);

        // Random histograms with random pixel traffic
        for (int f = 0; f < 6; f++) begin
            clear_pulse();
            for (int k = 0; k < NB; k++) begin
                rnd[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                     : int'($urandom_range(0, 5));
            end
            build_model(rnd);
            send_frame(rnd, 8, 7);
            chk("rnd_ready", lut_ready, 1);
            chk("rnd_err", lut_err, 0);
            stream(40, 30, 1'b0);
        end

        // Reset after beat 4 of a build, then a full uniform frame
        clear_pulse();
        send_frame(junk, 4, -1);
        do_reset("midbuild");
        build_model(uni);
        send_frame(uni, 8, 7);
        chk("postrst_ready", lut_ready, 1);
        check_all_lut();

        // Reset during MAP with a pending output leaves nothing behind
        pix_i = 3'd4; pix_valid = 1'b1; pix_o_ready = 1'b0;
        @(negedge aclk);
        pix_valid = 1'b0;
        chk("midmap_pending", pix_o_valid, 1);
        do_reset("midmap");
        pix_o_ready = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_histo_equalize_lut
`default_nettype wire
